// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state, opcode and control-field encodings for the multicycle controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RCOMPL  = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_TRAP    = 4'd12,
    S_IDLE    = 4'd15
  } stateT;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNe;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regWrite;
    logic       regDst;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       illegalOp;
  } ctrlT;

  // Moore strobes for a state; the FETCH ir_write/pc_write pair is qualified by mem_ready outside.
  function automatic ctrlT decodeCtrl(stateT s, logic isBne);
    ctrlT c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memRead = 1'b1;
        c.aluSrcB = SRCB_FOUR;
      end
      S_DECODE:  c.aluSrcB = SRCB_IMM_SH;
      S_MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        c.memRead = 1'b1;
        c.iOrD    = 1'b1;
      end
      S_MEMWB: begin
        c.regWrite = 1'b1;
        c.memToReg = 1'b1;
      end
      S_MEMWR: begin
        c.memWrite = 1'b1;
        c.iOrD     = 1'b1;
      end
      S_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = ALU_FUNCT;
      end
      S_RCOMPL: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      S_BRANCH: begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = ALU_SUB;
        c.pcWriteCond = 1'b1;
        c.pcSource    = PC_ALUOUT;
        c.branchNe    = isBne;
      end
      S_JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = PC_JUMP;
      end
      S_ADDI_EX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
      end
      S_ADDI_WB: c.regWrite = 1'b1;
      S_TRAP: begin
        c.pcWrite   = 1'b1;
        c.pcSource  = PC_EXC;
        c.illegalOp = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_dispatch.sv
// rtl/ctrl_dispatch.sv - opcode lookup for the DECODE and MEMADR next states
module ctrl_dispatch
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int TRAP_EN = 1
) (
  input  logic [OP_W-1:0] op,
  output stateT           decodeNext,
  output stateT           memAdrNext
);

  always_comb begin
    decodeNext = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
    if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW))
      decodeNext = S_MEMADR;
    else if (op == OP_W'(OP_R))
      decodeNext = S_EXEC;
    else if (op == OP_W'(OP_BEQ) || op == OP_W'(OP_BNE))
      decodeNext = S_BRANCH;
    else if (op == OP_W'(OP_J))
      decodeNext = S_JUMP;
    else if (op == OP_W'(OP_ADDI))
      decodeNext = S_ADDI_EX;
  end

  assign memAdrNext = (op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle datapath controller with memory wait and opcode trap
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int MEM_WAIT = 1,
  parameter int TRAP_EN  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            branch_ne,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            reg_dst,
  output logic [1:0]      pc_source,
  output logic [1:0]      alu_op,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            illegal_op,
  output logic [3:0]      state
);

  stateT stateQ;
  stateT nextState;
  stateT decodeNext;
  stateT memAdrNext;
  ctrlT  ctrlQ;
  logic  rdy;
  logic  isBne;
  logic  fetchGo;

  ctrl_dispatch #(
    .OP_W    (OP_W),
    .TRAP_EN (TRAP_EN)
  ) uDispatch (
    .op         (op),
    .decodeNext (decodeNext),
    .memAdrNext (memAdrNext)
  );

  assign rdy   = mem_ready || (MEM_WAIT == 0);
  assign isBne = (op == OP_W'(OP_BNE));

  always_comb begin
    nextState = S_FETCH;
    case (stateQ)
      S_IDLE:    nextState = S_FETCH;
      S_FETCH:   nextState = rdy ? S_DECODE : S_FETCH;
      S_DECODE:  nextState = decodeNext;
      S_MEMADR:  nextState = memAdrNext;
      S_MEMRD:   nextState = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   nextState = S_FETCH;
      S_MEMWR:   nextState = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:    nextState = S_RCOMPL;
      S_RCOMPL:  nextState = S_FETCH;
      S_BRANCH:  nextState = S_FETCH;
      S_JUMP:    nextState = S_FETCH;
      S_ADDI_EX: nextState = S_ADDI_WB;
      S_ADDI_WB: nextState = S_FETCH;
      S_TRAP:    nextState = S_FETCH;
      default:   nextState = S_FETCH;
    endcase
  end

  // Strobes are registered from the next state so they line up with stateQ; the async
  // reset clears them together with the state, which drops an in-flight mem_write at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= S_IDLE;
      ctrlQ  <= '0;
    end else begin
      stateQ <= nextState;
      ctrlQ  <= decodeCtrl(nextState, isBne);
    end
  end

  assign fetchGo = (stateQ == S_FETCH) && rdy;

  assign ir_write      = fetchGo;
  assign pc_write      = ctrlQ.pcWrite | fetchGo;
  assign pc_write_cond = ctrlQ.pcWriteCond;
  assign branch_ne     = ctrlQ.branchNe;
  assign i_or_d        = ctrlQ.iOrD;
  assign mem_read      = ctrlQ.memRead;
  assign mem_write     = ctrlQ.memWrite;
  assign mem_to_reg    = ctrlQ.memToReg;
  assign reg_write     = ctrlQ.regWrite;
  assign reg_dst       = ctrlQ.regDst;
  assign pc_source     = ctrlQ.pcSource;
  assign alu_op        = ctrlQ.aluOp;
  assign alu_src_a     = ctrlQ.aluSrcA;
  assign alu_src_b     = ctrlQ.aluSrcB;
  assign illegal_op    = ctrlQ.illegalOp;
  assign state         = stateQ;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized bench for multicycle_ctrl_fsm against a phase-list model
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] op = 6'd0;

  logic pw1, pwc1, bne1, iod1, mr1, mw1, irw1, m2r1, rw1, rd1, sa1, ill1;
  logic [1:0] pcs1, aop1, sb1;
  logic [3:0] state1;
  logic pw2, pwc2, bne2, iod2, mr2, mw2, irw2, m2r2, rw2, rd2, sa2, ill2;
  logic [1:0] pcs2, aop2, sb2;
  logic [3:0] state2;

  logic [17:0] obs1, obs2;
  assign obs1 = {pw1, pwc1, bne1, iod1, mr1, mw1, irw1, m2r1, rw1, rd1, pcs1, aop1, sa1, sb1, ill1};
  assign obs2 = {pw2, pwc2, bne2, iod2, mr2, mw2, irw2, m2r2, rw2, rd2, pcs2, aop2, sa2, sb2, ill2};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.OP_W(6), .MEM_WAIT(1), .TRAP_EN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pw1), .pc_write_cond(pwc1), .branch_ne(bne1), .i_or_d(iod1),
    .mem_read(mr1), .mem_write(mw1), .ir_write(irw1), .mem_to_reg(m2r1),
    .reg_write(rw1), .reg_dst(rd1), .pc_source(pcs1), .alu_op(aop1),
    .alu_src_a(sa1), .alu_src_b(sb1), .illegal_op(ill1), .state(state1)
  );

  multicycle_ctrl_fsm #(.OP_W(6), .MEM_WAIT(0), .TRAP_EN(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pw2), .pc_write_cond(pwc2), .branch_ne(bne2), .i_or_d(iod2),
    .mem_read(mr2), .mem_write(mw2), .ir_write(irw2), .mem_to_reg(m2r2),
    .reg_write(rw2), .reg_dst(rd2), .pc_source(pcs2), .alu_op(aop2),
    .alu_src_a(sa2), .alu_src_b(sb2), .illegal_op(ill2), .state(state2)
  );

  // Expected strobes per state code, packed in the same order as obs1/obs2.
  function automatic logic [17:0] expOut(int code, bit isBne, bit rdy);
    logic pw, pwc, bn, iod, mr, mw, irw, m2r, rw, rd, sa, ill;
    logic [1:0] pcs, aop, sb;
    {pw, pwc, bn, iod, mr, mw, irw, m2r, rw, rd, sa, ill} = '0;
    pcs = 2'b00; aop = 2'b00; sb = 2'b00;
    case (code)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; bn = isBne; end
      9:  begin pw = 1; pcs = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: begin pw = 1; pcs = 2'b11; ill = 1; end
      default: ;
    endcase
    return {pw, pwc, bn, iod, mr, mw, irw, m2r, rw, rd, pcs, aop, sa, sb, ill};
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH; dut 1 waits on memory and traps, dut 2 does neither.
  task automatic runInstr(input int dutSel, input logic [5:0] opc, input int fetchWaits, input int memWaits);
    int ph[$];
    int idx, waitsLeft, cur;
    bit isMem, rdy, memWait, trapEn;
    logic [3:0] st;
    logic [17:0] got, want;
    memWait = (dutSel == 1);
    trapEn  = (dutSel == 1);
    ph = {0, 1};
    case (opc)
      OP_R:           begin ph.push_back(6); ph.push_back(7); end
      OP_LW:          begin ph.push_back(2); ph.push_back(3); ph.push_back(4); end
      OP_SW:          begin ph.push_back(2); ph.push_back(5); end
      OP_BEQ, OP_BNE: ph.push_back(8);
      OP_J:           ph.push_back(9);
      OP_ADDI:        begin ph.push_back(10); ph.push_back(11); end
      default:        if (trapEn) ph.push_back(12);
    endcase
    op = opc;
    idx = 0;
    waitsLeft = fetchWaits;
    while (idx < ph.size()) begin
      cur = ph[idx];
      isMem = (cur == 0 || cur == 3 || cur == 5);
      if (isMem) mem_ready = (waitsLeft == 0);
      else mem_ready = 1'($urandom);
      rdy = mem_ready || !memWait;
      #1;
      st  = (dutSel == 1) ? state1 : state2;
      got = (dutSel == 1) ? obs1 : obs2;
      want = expOut(cur, opc == OP_BNE, rdy);
      checks++;
      if (st !== 4'(cur)) begin
        errors++;
        $display("FAIL state dut%0d op=%b step=%0d got=%0d want=%0d", dutSel, opc, idx, st, cur);
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL strobes dut%0d op=%b state=%0d got=%b want=%b", dutSel, opc, cur, got, want);
      end
      if (!isMem || rdy) begin
        idx++;
        waitsLeft = 0;
        if (idx < ph.size() && (ph[idx] == 3 || ph[idx] == 5)) waitsLeft = memWaits;
      end else begin
        waitsLeft--;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    op = OP_LW;
    mem_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (state1 !== 4'd15 || state2 !== 4'd15) begin
        errors++;
        $display("FAIL reset_state got=%0d/%0d want=15", state1, state2);
      end
      checks++;
      if (obs1 !== '0 || obs2 !== '0) begin
        errors++;
        $display("FAIL reset_outputs got=%b/%b want=0", obs1, obs2);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (state1 !== 4'd15 || obs1 !== '0) begin
      errors++;
      $display("FAIL release_idle got state=%0d out=%b want state=15 out=0", state1, obs1);
    end
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (state1 !== 4'd0 || irw1 !== 1'b1) begin
      errors++;
      $display("FAIL first_fetch got state=%0d ir_write=%b want state=0 ir_write=1", state1, irw1);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (state1 !== 4'd15 || obs1 !== '0) begin
      errors++;
      $display("FAIL async_reset got state=%0d out=%b want state=15 out=0", state1, obs1);
    end
    doReset();
  endtask

  task automatic test_lw_wait();
    doReset();
    runInstr(1, OP_LW, 0, 2);
    runInstr(1, OP_LW, 2, 1);
  endtask

  task automatic test_sw_bne();
    doReset();
    runInstr(1, OP_SW, 0, 0);
    runInstr(1, OP_BNE, 0, 0);
    runInstr(1, OP_BEQ, 1, 0);
    runInstr(1, OP_SW, 1, 3);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [3];
    int lens [3];
    int n;
    ops = '{OP_R, OP_J, OP_ADDI};
    lens = '{4, 3, 4};
    doReset();
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op = ops[k];
      n = 0;
      #1;
      while (1) begin
        if (state1 == 4'd9) begin
          checks++;
          if (pcs1 !== 2'b10) begin errors++; $display("FAIL jump_pc_source got=%b want=10", pcs1); end
        end
        if (state1 == 4'd7) begin
          checks++;
          if (rd1 !== 1'b1) begin errors++; $display("FAIL rcompl_reg_dst got=%b want=1", rd1); end
        end
        if (state1 == 4'd11) begin
          checks++;
          if (rd1 !== 1'b0 || rw1 !== 1'b1) begin
            errors++;
            $display("FAIL addi_wb got reg_dst=%b reg_write=%b want 0/1", rd1, rw1);
          end
        end
        @(posedge clk); @(negedge clk); #1;
        n++;
        if (state1 == 4'd0 || n >= 20) break;
      end
      checks++;
      if (n !== lens[k]) begin
        errors++;
        $display("FAIL instr_length op=%b got=%0d want=%0d", ops[k], n, lens[k]);
      end
    end
  endtask

  task automatic test_trap();
    doReset();
    runInstr(1, 6'b111111, 0, 0);
    runInstr(1, 6'b111111, 2, 0);
    doReset();
    runInstr(2, 6'b111111, 1, 0);
    runInstr(2, OP_LW, 2, 2);
    runInstr(2, OP_SW, 1, 3);
  endtask

  task automatic test_reset_memwr();
    doReset();
    op = OP_SW;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state1 !== 4'd5 || mw1 !== 1'b1) begin
      errors++;
      $display("FAIL memwr_hold got state=%0d mem_write=%b want 5/1", state1, mw1);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mw1 !== 1'b0 || state1 !== 4'd15) begin
      errors++;
      $display("FAIL memwr_abort got state=%0d mem_write=%b want 15/0", state1, mw1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (state1 !== 4'd15 || obs1 !== '0) begin
      errors++;
      $display("FAIL abort_idle got state=%0d out=%b want 15/0", state1, obs1);
    end
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (state1 !== 4'd0) begin
      errors++;
      $display("FAIL abort_restart got state=%0d want=0", state1);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int dutSel, input int count);
    logic [5:0] legal [7];
    logic [5:0] o;
    int k;
    legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
    doReset();
    for (int i = 0; i < count; i++) begin
      k = $urandom_range(0, 7);
      if (k < 7) o = legal[k];
      else begin
        do o = 6'($urandom); while (o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI});
      end
      runInstr(dutSel, o, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw_wait();
    test_sw_bne();
    test_back_to_back();
    test_trap();
    test_reset_memwr();
    test_random(1, 40);
    test_random(2, 25);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Parametrised multicycle datapath controller. It holds its own state register and derives all datapath control strobes from the current state and the instruction opcode. Compared with the previous combinational control array, it adds `bne`, a memory-ready wait handshake, an illegal-opcode trap and a quiet post-reset state. It sits between the instruction register's opcode field and the multicycle datapath: PC, memory port, register file and ALU.

## Interface
Parameters:
- `OP_W`, 6: opcode width.
- `MEM_WAIT`, 1: 1 = memory states hold until `mem_ready`; 0 = `mem_ready` is ignored and treated as 1.
- `TRAP_EN`, 1: 1 = unknown opcodes go to TRAP; 0 = unknown opcodes return to FETCH and execute as a NOP.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in OP_W: opcode from IR; stable from DECODE until the instruction retires.
- `mem_ready` in 1: memory completed the current access this cycle.
- `pc_write`, `pc_write_cond`, `branch_ne` out 1 each.
- `i_or_d`, `mem_read`, `mem_write`, `ir_write` out 1 each.
- `mem_to_reg`, `reg_write`, `reg_dst` out 1 each.
- `pc_source` out 2: 00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- `alu_op` out 2: 00 add, 01 sub, 10 funct.
- `alu_src_a` out 1: 0 PC, 1 A.
- `alu_src_b` out 2: 00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- `illegal_op` out 1: one-cycle trap pulse.
- `state` out 4: current state, for debug.

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RCOMPL 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, TRAP 12, IDLE 15. Codes 13 and 14 are unused and go to FETCH.
- Outputs are a Moore decode of `state`, except the `mem_ready` qualifications noted below. Any strobe not listed for a state is 0 and its bus is 00.
- IDLE: all outputs 0. Next state FETCH.
- FETCH: `mem_read`=1, `alu_src_b`=01.
  - `ir_write` = `pc_write` = `rdy`, where `rdy` = `mem_ready` or !MEM_WAIT.
  - Go to DECODE when `rdy`, else hold.
- DECODE: `alu_src_b`=11.
  - Dispatch: lw/sw to MEMADR; R to EXEC; beq/bne to BRANCH; j to JUMP; addi to ADDI_EX.
  - Any other opcode goes to TRAP if TRAP_EN, else FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `i_or_d`=1. Go to MEMWB when `rdy`, else hold.
- MEMWB: `reg_write`=1, `mem_to_reg`=1. Next FETCH.
- MEMWR: `mem_write`=1, `i_or_d`=1. Go to FETCH when `rdy`, else hold with `mem_write` still asserted.
- EXEC: `alu_src_a`=1, `alu_op`=10. Next RCOMPL.
- RCOMPL: `reg_write`=1, `reg_dst`=1. Next FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `branch_ne`=(`op`==bne). Next FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Next FETCH.
- ADDI_EX: `alu_src_a`=1, `alu_src_b`=10. Next ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0. Next FETCH.
- TRAP: `pc_write`=1, `pc_source`=11, `illegal_op`=1. Next FETCH.

## Timing
- Reset: `reset_n` low forces `state`=IDLE immediately, with no clock edge needed. All outputs read 0 while reset is held and during the first cycle after release.
- Reset mid-instruction aborts it with no further strobes. A `mem_write` in progress drops combinationally.
- First FETCH is the cycle after the first rising edge with `reset_n` high.
- Instruction length in cycles with zero wait: R 4, lw 5, sw 4, beq/bne 3, j 3, addi 4, trap 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs are held, and `ir_write`/`pc_write` stay 0 in FETCH.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored in every other state.
- `mem_ready` high in the same cycle as `reset_n` low has no effect.
- `illegal_op` is high for exactly one cycle per illegal instruction.

## Structure
- Package `ctrl_pkg`:
  - state encoding constants and state typedef;
  - opcode constants;
  - `alu_op`, `pc_source` and `alu_src_b` encodings.
- Sub-module `ctrl_dispatch`: combinational lookup from `op` and `TRAP_EN` to the DECODE and MEMADR next states.
- Top level: state register, next-state mux, output decode.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `op`=lw and `mem_ready`=1 → `state`=15 and all outputs 0; after release, `state` goes 15→0 and `ir_write`=1 in the first FETCH.
- lw, MEM_WAIT=1, `mem_ready` low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; `reg_write`=`mem_to_reg`=1 only in state 4.
- sw then bne, zero wait → states 0,1,2,5 then 0,1,8; `mem_write`=1 for exactly one cycle; `branch_ne`=1, `pc_write_cond`=1, `alu_op`=01 in state 8.
- R-type, j and addi back to back → 4, 3 and 4 cycles; `pc_source`=10 in JUMP; `reg_dst`=1 in RCOMPL and 0 in ADDI_WB.
- `op`=111111: with TRAP_EN=1 → states 0,1,12,0, `illegal_op` high for one cycle, `pc_source`=11. With TRAP_EN=0 → states 0,1,0 and no strobes.
- `reset_n` pulsed low while in MEMWR with `mem_ready`=0 → `mem_write` drops to 0 before the next edge; the controller restarts from IDLE.
